cisr_job_ctrl: RTL
==================

// Module: cisr_job_ctrl
// PURPOSE
//  Job sequencer for the CISR SpMV accumulator. Accepts a start command with a row count, holds the
//  accumulator in reset, then runs the job. Forwards accumulator result writes to the result-vector
//  memory and tracks which row ids have completed. Signals done when every row is written, or flags
//  an error on timeout or an out-of-range row id.
// PARAMETERS
//  ROW_ID_SIZE    8     row id width; must match accumulator row_id_size; max rows = 2**ROW_ID_SIZE
//  ACC_SIZE       32    accumulator result width
//  INIT_CYCLES    2     cycles acc_rst is held high in INIT (>=1)
//  TIMEOUT_CYCLES 4096  RUN cycles with no new row completed before error; 0 disables the watchdog
// PORTS
//  clk            in   1              clock
//  rst            in   1              asynchronous reset, active-low
//  start          in   1              start pulse; sampled in IDLE only
//  abort          in   1              abandon the job and return to IDLE
//  num_rows       in   ROW_ID_SIZE+1  rows in the job; sampled with start
//  busy           out  1              high in INIT and RUN
//  done           out  1              1-cycle pulse at job end (success or error)
//  err            out  2              00 ok, 01 timeout, 10 bad row id, 11 num_rows too large; valid with done, held until next start
//  acc_rst        out  1              synchronous active-high reset to the accumulator
//  acc_write_data in   1              accumulator write strobe
//  acc_addr       in   ROW_ID_SIZE    accumulator row id
//  acc_data       in   ACC_SIZE       accumulator result
//  mem_we         out  1              result memory write enable
//  mem_addr       out  ROW_ID_SIZE    result memory address
//  mem_wdata      out  ACC_SIZE       result memory data
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; busy, done, mem_we=0; err=00; acc_rst=1; rows_done=0; bitmap cleared.
//  Datapath reset: acc_rst=1 in IDLE and INIT, 0 only in RUN. The accumulator never runs outside a job.
//  FSM states: IDLE, INIT, RUN, FIN.
//   IDLE -> INIT on start. Latch num_rows, clear err, rows_done, the 2**ROW_ID_SIZE-bit bitmap and the watchdog.
//   If num_rows > 2**ROW_ID_SIZE: go IDLE -> FIN directly with err=11.
//   INIT: count INIT_CYCLES cycles, then enter RUN.
//   If num_rows==0, go INIT -> FIN with err=00 instead of entering RUN.
//   RUN: each cycle with acc_write_data=1 is handled as follows.
//    acc_addr >= num_rows: no memory write; set err=10; go FIN.
//    Otherwise drive mem_we/addr/wdata registered, 1 cycle after the strobe.
//    Repeated writes to the same id, caused by accumulator stalls, are written again (last value wins)
//    but are counted only once.
//    First write to an id sets its bitmap bit, increments rows_done and clears the watchdog.
//   RUN -> FIN when rows_done reaches num_rows. The completing write is still issued to memory.
//   RUN -> FIN with err=01 when the watchdog reaches TIMEOUT_CYCLES.
//   FIN: done=1 for exactly 1 cycle, then go IDLE. mem_we is forced to 0 in FIN and IDLE.
//  abort: in INIT, RUN or FIN, go to IDLE next cycle with no done pulse. Any pending mem_we is squashed.
//  Simultaneous events:
//   abort beats completion, timeout and start.
//   A bad id beats completion in the same cycle.
//   start in any state other than IDLE is ignored.
//  Width rules: rows_done and the watchdog saturate (no wrap). acc_data is passed through unmodified.
//  Latency: start -> RUN = 1+INIT_CYCLES cycles. Strobe -> mem_we = 1 cycle.
//   Final strobe -> done = 2 cycles (RUN->FIN, then FIN pulse).
//  Asserting rst mid-job aborts immediately to the reset values above. No memory write is issued.
// STRUCTURE
//  Shared package (params.vh): ROW_ID_SIZE, ACC_SIZE, err code constants ERR_OK/TIMEOUT/BADID/SIZE,
//   and state encoding localparams.
//  Sub-module cisr_row_bitmap holds the completed-row bitmap.
//   Interface: clear, set+idx, returns was_set for idx; single-cycle clear.
// TESTING
//  1. num_rows=4; write ids 0,1,2,3 once each -> 4 mem writes; done 2 cycles after id 3; err=00.
//  2. num_rows=3; ids 0,0,0,1,2 with data 5,6,7,8,9 -> 5 mem writes; last write to addr 0 is 7; done; err=00.
//  3. num_rows=2; strobe id 5 -> no mem_we; done; err=10.
//  4. TIMEOUT_CYCLES=16, num_rows=2; one write then idle -> done 16 cycles after that write; err=01.
//  5. num_rows=0 -> done at cycle 1+INIT_CYCLES+1; num_rows=2**ROW_ID_SIZE+1 -> done after 1 cycle; err=11.
//  6. abort mid-RUN, or rst low mid-RUN -> IDLE, no done, acc_rst=1, mem_we=0; next start works normally.

Source files
------------

// File: rtl/cisr_job_ctrl_pkg.sv
// Shared constants and types for the CISR SpMV job sequencer.
package cisr_job_ctrl_pkg;

  localparam int ROW_ID_SIZE = 8;
  localparam int ACC_SIZE    = 32;
  localparam int MAX_ROWS    = 1 << ROW_ID_SIZE;

  typedef logic [ROW_ID_SIZE-1:0] row_id_t;
  typedef logic [ROW_ID_SIZE:0]   row_cnt_t;
  typedef logic [ACC_SIZE-1:0]    acc_data_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADID   = 2'b10;
  localparam logic [1:0] ERR_SIZE    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Saturating increment for row counters.
  function automatic row_cnt_t sat_inc(row_cnt_t v);
    return (v == '1) ? v : v + row_cnt_t'(1);
  endfunction

endpackage

// File: rtl/cisr_job_ctrl_if.sv
// Command, accumulator and result-memory signals of the job sequencer.
interface cisr_job_ctrl_if;
  import cisr_job_ctrl_pkg::*;

  logic      start;
  logic      abort;
  row_cnt_t  num_rows;
  logic      busy;
  logic      done;
  logic [1:0] err;
  logic      acc_rst;
  logic      acc_write_data;
  row_id_t   acc_addr;
  acc_data_t acc_data;
  logic      mem_we;
  row_id_t   mem_addr;
  acc_data_t mem_wdata;

  // Host / accumulator / memory side.
  modport master (
    output start, abort, num_rows, acc_write_data, acc_addr, acc_data,
    input  busy, done, err, acc_rst, mem_we, mem_addr, mem_wdata
  );

  // Sequencer side.
  modport slave (
    input  start, abort, num_rows, acc_write_data, acc_addr, acc_data,
    output busy, done, err, acc_rst, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cisr_row_bitmap.sv
// One bit per row id, set on the first write of that row in a job.
module cisr_row_bitmap
  import cisr_job_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    set,
  input  row_id_t idx,
  output logic    was_set
);

  logic [MAX_ROWS-1:0] bits;

  assign was_set = bits[idx];

  // Clear wins over set; clear takes a single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       bits      <= '0;
    else if (clear) bits      <= '0;
    else if (set)   bits[idx] <= 1'b1;
  end

endmodule

// File: rtl/cisr_job_ctrl.sv
// CISR SpMV job sequencer: holds the accumulator in reset around a job,
// forwards result writes to memory and reports done / error.
module cisr_job_ctrl
  import cisr_job_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  cisr_job_ctrl_if.slave bus
);

  localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IC_W-1:0] INIT_LAST = IC_W'(INIT_CYCLES - 1);

  // The watchdog counts cycles since the last completing strobe (that strobe
  // is cycle 0). It trips two counts early so that the FIN cycle and the
  // done pulse land exactly TIMEOUT_CYCLES after that strobe. Windows
  // shorter than that tail trip on the first idle cycle.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_TRIP =
    (TIMEOUT_CYCLES > 2) ? WD_W'(TIMEOUT_CYCLES - 2) : WD_W'(1);

  state_t          state;
  row_cnt_t        num_rows_q;
  row_cnt_t        rows_done;
  logic [IC_W-1:0] init_cnt;
  logic [WD_W-1:0] wd;

  logic       busy_q, done_q, acc_rst_q, mem_we_q;
  logic [1:0] err_q;
  row_id_t    mem_addr_q;
  acc_data_t  mem_wdata_q;

  logic strb, id_bad, was_set, first_wr, bm_clr, last_row, wd_trip;

  // Strobes only count in RUN; abort squashes the strobe of its cycle.
  assign strb     = (state == S_RUN) && bus.acc_write_data && !bus.abort;
  assign id_bad   = {1'b0, bus.acc_addr} >= num_rows_q;
  assign first_wr = strb && !id_bad && !was_set;
  assign bm_clr   = (state == S_IDLE) && bus.start && !bus.abort;
  assign last_row = (rows_done + row_cnt_t'(1)) == num_rows_q;
  assign wd_trip  = (TIMEOUT_CYCLES != 0) && (wd >= WD_TRIP);

  cisr_row_bitmap u_bitmap (
    .clk     (clk),
    .rst     (rst),
    .clear   (bm_clr),
    .set     (first_wr),
    .idx     (bus.acc_addr),
    .was_set (was_set)
  );

  // Job FSM with registered status and memory-write outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      acc_rst_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      num_rows_q  <= '0;
      rows_done   <= '0;
      init_cnt    <= '0;
      wd          <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            num_rows_q <= bus.num_rows;
            rows_done  <= '0;
            init_cnt   <= '0;
            wd         <= '0;
            if (bus.num_rows > row_cnt_t'(MAX_ROWS)) begin
              err_q <= ERR_SIZE;
              state <= S_FIN;
            end else begin
              err_q  <= ERR_OK;
              busy_q <= 1'b1;
              state  <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (init_cnt == INIT_LAST) begin
            if (num_rows_q == '0) begin
              busy_q <= 1'b0;
              state  <= S_FIN;
            end else begin
              acc_rst_q <= 1'b0;
              wd        <= WD_W'(1);
              state     <= S_RUN;
            end
          end else begin
            init_cnt <= init_cnt + IC_W'(1);
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            busy_q    <= 1'b0;
            acc_rst_q <= 1'b1;
            state     <= S_IDLE;
          end else if (strb && id_bad) begin
            // Bad id beats completion; nothing goes to memory.
            err_q     <= ERR_BADID;
            busy_q    <= 1'b0;
            acc_rst_q <= 1'b1;
            state     <= S_FIN;
          end else begin
            // Repeated ids are rewritten (last value wins) but counted once.
            if (strb) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= bus.acc_addr;
              mem_wdata_q <= bus.acc_data;
            end
            if (first_wr) begin
              rows_done <= sat_inc(rows_done);
              wd        <= WD_W'(1);
            end else if (wd != '1) begin
              wd <= wd + WD_W'(1);
            end
            // The completing write is still issued; it shows up during FIN.
            if (first_wr && last_row) begin
              busy_q    <= 1'b0;
              acc_rst_q <= 1'b1;
              state     <= S_FIN;
            end else if (!first_wr && wd_trip) begin
              err_q     <= ERR_TIMEOUT;
              busy_q    <= 1'b0;
              acc_rst_q <= 1'b1;
              state     <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done_q <= !bus.abort;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.acc_rst   = acc_rst_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
